// File: rtl/uart_txb_pkg.sv
// Shared constants for the UART TX buffer: local register offsets, UART offsets, drain FSM states.
// Used by uart_tx_buffer and uart_txb_fifo.
package uart_txb_pkg;

  localparam logic [7:0] OFS_TXPUSH = 8'h40;
  localparam logic [7:0] OFS_STATUS = 8'h44;
  localparam logic [7:0] OFS_CTRL   = 8'h48;
  localparam logic [7:0] OFS_OVFCNT = 8'h4C;

  localparam logic [7:0] UART_OFS_STATUS = 8'h04;
  localparam logic [7:0] UART_OFS_TXDATA = 8'h0C;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_POLL   = 4'b0010,
    ST_WRITE  = 4'b0100,
    ST_SETTLE = 4'b1000
  } drain_state_t;

  function automatic logic is_local(input logic [7:0] ofs);
    return ofs inside {OFS_TXPUSH, OFS_STATUS, OFS_CTRL, OFS_OVFCNT};
  endfunction

endpackage

// File: rtl/uart_txb_fifo.sv
// DEPTH x 8 synchronous FIFO with flush; pointers carry one extra wrap bit.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module uart_txb_fifo
  import uart_txb_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  logic [7:0]    i_data,
  output logic [7:0]    o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_drop,
  output logic [AW:0]   o_level
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        w_push_ok;
  logic        w_pop_ok;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_level = r_wptr - r_rptr;
  assign o_head  = r_mem[r_rptr[AW-1:0]];

  assign w_pop_ok  = i_pop && !o_empty && !i_flush;
  assign w_push_ok = i_push && !i_flush && (!o_full || w_pop_ok);
  // flush swallows a same-cycle push silently; only a genuine overflow is a drop
  assign o_drop    = i_push && !i_flush && !w_push_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop_ok)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// Bus slave in front of the UART: buffers TX bytes and drains them via STATUS polling.
// Define UART_TXB_OVF_CNT_EN to build the 16-bit OVFCNT register at 0x4C.
module uart_tx_buffer
  import uart_txb_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        uart_we_o,
  output logic        uart_req_o,
  output logic [31:0] uart_addr_o,
  output logic [31:0] uart_data_o,
  input  logic [31:0] uart_data_i
);

  logic [7:0]   w_ofs;
  logic         w_local;
  logic         w_fwd;
  logic         w_wr;
  logic         w_push;
  logic         w_ctrl_wr;
  logic         w_flush;
  logic         w_ovf_clr;

  logic [7:0]   w_head;
  logic         w_full;
  logic         w_empty;
  logic         w_drop;
  logic [AW:0]  w_level;
  logic [7:0]   w_level8;

  logic         r_drain_en;
  logic         r_ovf;
  logic [15:0]  w_ovf_cnt_rd;
  logic [31:0]  w_local_rd;

  drain_state_t r_state;
  drain_state_t w_state_nxt;
  logic         w_pop;
  logic         w_fsm_req;
  logic         w_fsm_we;
  logic [31:0]  w_fsm_addr;
  logic [31:0]  w_fsm_data;

  assign w_ofs     = addr_i[7:0];
  assign w_local   = is_local(w_ofs);
  assign w_fwd     = req_i && !w_local && !rst;
  assign w_wr      = req_i && we_i;
  assign w_push    = w_wr && (w_ofs == OFS_TXPUSH);
  assign w_ctrl_wr = w_wr && (w_ofs == OFS_CTRL);
  assign w_flush   = w_ctrl_wr && data_i[1];
  assign w_ovf_clr = w_ctrl_wr && data_i[2];

  uart_txb_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  (data_i[7:0]),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_drop  (w_drop),
    .o_level (w_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drain_en <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_drain_en <= data_i[0];
      if (w_ovf_clr)   r_ovf <= 1'b0;
      else if (w_drop) r_ovf <= 1'b1;
    end
  end

`ifdef UART_TXB_OVF_CNT_EN
  logic [15:0] r_ovf_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf_cnt <= '0;
    end else if (w_ovf_clr) begin
      r_ovf_cnt <= '0;
    end else if (w_drop && (r_ovf_cnt != 16'hFFFF)) begin
      r_ovf_cnt <= r_ovf_cnt + 16'd1;
    end
  end

  assign w_ovf_cnt_rd = r_ovf_cnt;
`else
  assign w_ovf_cnt_rd = 16'h0000;
`endif

  assign w_level8 = 8'(w_level);

  always_comb begin
    w_local_rd = 32'h0;
    case (w_ofs)
      OFS_STATUS: w_local_rd = {16'h0, w_level8, 5'h0, r_ovf, w_empty, w_full};
      OFS_CTRL:   w_local_rd = {31'h0, r_drain_en};
      OFS_OVFCNT: w_local_rd = {16'h0, w_ovf_cnt_rd};
      default:    w_local_rd = 32'h0;
    endcase
  end

  assign ack_o  = req_i;
  assign data_o = w_fwd ? uart_data_i : ((req_i && w_local) ? w_local_rd : 32'h0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // While the CPU owns the UART port the FSM drives nothing and holds its state.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_fsm_req   = 1'b0;
    w_fsm_we    = 1'b0;
    w_fsm_addr  = 32'h0;
    w_fsm_data  = 32'h0;
    case (r_state)
      ST_IDLE: begin
        if (r_drain_en && !w_empty) w_state_nxt = ST_POLL;
      end
      ST_POLL: begin
        if (!r_drain_en || w_empty) begin
          w_state_nxt = ST_IDLE;
        end else if (!w_fwd) begin
          w_fsm_req  = 1'b1;
          w_fsm_addr = {24'h0, UART_OFS_STATUS};
          if (!uart_data_i[0]) w_state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (w_flush) begin
          w_state_nxt = ST_IDLE;
        end else if (!w_fwd) begin
          w_fsm_req   = 1'b1;
          w_fsm_we    = 1'b1;
          w_fsm_addr  = {24'h0, UART_OFS_TXDATA};
          w_fsm_data  = {24'h0, w_head};
          w_pop       = 1'b1;
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign uart_req_o  = w_fwd ? req_i  : w_fsm_req;
  assign uart_we_o   = w_fwd ? we_i   : w_fsm_we;
  assign uart_addr_o = w_fwd ? addr_i : w_fsm_addr;
  assign uart_data_o = w_fwd ? data_i : w_fsm_data;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer with a busy-flag UART model and a TX byte scoreboard.
module tb_uart_tx_buffer;

  localparam int BUSY_CYC = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i, req_i;
  logic [31:0] addr_i, data_i, data_o;
  logic        ack_o;
  logic        uart_we_o, uart_req_o;
  logic [31:0] uart_addr_o, uart_data_o, uart_data_i;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  q_head;
  int          n_tx = 0;
  int          n_baud = 0;
  logic [31:0] last_baud = 32'h0;
  int          busy_cnt = 0;
  logic        busy_hold = 1'b0;
  logic        busy;
  logic        txwr = 1'b0;
  logic        txwr_flag = 1'b0;
  logic        prev_txwr = 1'b0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  uart_tx_buffer #(.DEPTH(16), .AW(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .we_i        (we_i),
    .req_i       (req_i),
    .addr_i      (addr_i),
    .data_i      (data_i),
    .data_o      (data_o),
    .ack_o       (ack_o),
    .uart_we_o   (uart_we_o),
    .uart_req_o  (uart_req_o),
    .uart_addr_o (uart_addr_o),
    .uart_data_o (uart_data_o),
    .uart_data_i (uart_data_i)
  );

  assign busy = (busy_cnt != 0) || busy_hold;
  assign uart_data_i = (uart_addr_o[7:0] == 8'h04) ? {31'h0, busy}
                                                   : (32'hA5A5_0000 | {24'h0, uart_addr_o[7:0]});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    if (txwr_flag)         busy_cnt <= BUSY_CYC;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  always begin
    @(negedge clk);
    #3;
    txwr = uart_req_o && uart_we_o && (uart_addr_o[7:0] == 8'h0C);
    if (txwr) begin
      check("tx_while_busy", {31'h0, busy}, 32'h0);
      check("tx_we_single_cycle", {31'h0, prev_txwr}, 32'h0);
      if (exp_q.size() == 0) begin
        check("tx_unexpected_byte", 32'(exp_q.size()), 32'd1);
      end else begin
        q_head = exp_q.pop_front();
        check("tx_byte", uart_data_o, {24'h0, q_head});
      end
      n_tx++;
    end
    if (uart_req_o && uart_we_o && (uart_addr_o[7:0] == 8'h08)) begin
      n_baud++;
      last_baud = uart_data_o;
    end
    prev_txwr = txwr;
    txwr_flag = txwr;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; addr_i = {24'h0, a}; data_i = d;
    @(negedge clk);
    req_i = 1'b0; we_i = 1'b0; addr_i = 32'h0; data_i = 32'h0;
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = {24'h0, a}; data_i = 32'h0;
    #1;
    d = data_o;
    check("ack", {31'h0, ack_o}, 32'h1);
    @(negedge clk);
    req_i = 1'b0; addr_i = 32'h0;
  endtask

  task automatic push(input logic [7:0] b, input bit sent);
    bus_wr(8'h40, {24'h0, b});
    if (sent) exp_q.push_back(b);
  endtask

  task automatic wait_drained(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || busy_cnt != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    cyc(3);
    check("drain_timeout", 32'(exp_q.size()), 32'h0);
  endtask

  task automatic expect_poll(input string tag);
    #1;
    check(tag, uart_addr_o, 32'h04);
    check({tag, "_req"}, {31'h0, uart_req_o}, 32'h1);
  endtask

  initial begin
    rst = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = 32'h0; data_i = 32'h0;
    #2;
    check("rst_uart_we", {31'h0, uart_we_o}, 32'h0);
    check("rst_uart_req", {31'h0, uart_req_o}, 32'h0);
    check("rst_uart_addr", uart_addr_o, 32'h0);
    check("rst_uart_data", uart_data_o, 32'h0);
    cyc(2);
    rst = 1'b0;
    bus_rd(8'h44, rd); check("rst_status", rd, 32'h0000_0002);
    bus_rd(8'h48, rd); check("rst_ctrl", rd, 32'h0);

    // 1: three bytes drained in order against a 20-cycle busy UART
    bus_wr(8'h48, 32'h1);
    push(8'h55, 1'b1);
    push(8'hA3, 1'b1);
    push(8'h0F, 1'b1);
    wait_drained(400);
    check("t1_tx_count", 32'(n_tx), 32'd3);

    bus_rd(8'h00, rd); check("fwd_read", rd, 32'hA5A5_0000);

    // 4: CPU BAUD writes collide with POLL, then with WRITE
    busy_hold = 1'b1;
    push(8'h11, 1'b1);
    cyc(3);
    expect_poll("t4_poll");
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h08; data_i = 32'h0000_1234;
    #1;
    check("t4_fwd_addr_poll", uart_addr_o, 32'h08);
    check("t4_fwd_data_poll", uart_data_o, 32'h0000_1234);
    check("t4_fwd_we_poll", {31'h0, uart_we_o}, 32'h1);
    @(negedge clk);
    req_i = 1'b0; we_i = 1'b0; addr_i = 32'h0; data_i = 32'h0;
    expect_poll("t4_poll_after");
    busy_hold = 1'b0;
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h08; data_i = 32'h0000_5678;
    #1;
    check("t4_fwd_addr_write", uart_addr_o, 32'h08);
    check("t4_fwd_data_write", uart_data_o, 32'h0000_5678);
    @(negedge clk);
    req_i = 1'b0; we_i = 1'b0; addr_i = 32'h0; data_i = 32'h0;
    #1;
    check("t4_retry_addr", uart_addr_o, 32'h0C);
    check("t4_retry_data", uart_data_o, 32'h11);
    wait_drained(200);
    check("t4_baud_count", 32'(n_baud), 32'd2);
    check("t4_baud_last", last_baud, 32'h0000_5678);
    check("t4_tx_count", 32'(n_tx), 32'd4);

    // 2: overflow with drain disabled
    bus_wr(8'h48, 32'h0);
    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i), 1'b1);
    push(8'hEE, 1'b0);
    bus_rd(8'h44, rd); check("t2_status_ovf", rd, 32'h0000_1005);
    bus_rd(8'h4C, rd);
`ifdef UART_TXB_OVF_CNT_EN
    check("t2_ovfcnt", rd, 32'h1);
`else
    check("t2_ovfcnt", rd, 32'h0);
`endif
    bus_wr(8'h48, 32'h4);
    bus_rd(8'h44, rd); check("t2_status_clr", rd, 32'h0000_1001);

    // 3: push into a full FIFO in the WRITE pop cycle
    busy_hold = 1'b1;
    bus_wr(8'h48, 32'h1);
    cyc(3);
    expect_poll("t3_poll");
    busy_hold = 1'b0;
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h40; data_i = 32'h77;
    exp_q.push_back(8'h77);
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h44; data_i = 32'h0;
    #1;
    check("t3_status", data_o, 32'h0000_1001);
    @(negedge clk);
    req_i = 1'b0; addr_i = 32'h0;
    wait_drained(1000);
    check("t3_tx_count", 32'(n_tx), 32'd21);

    // 5: flush in the WRITE cycle
    busy_hold = 1'b1;
    push(8'h99, 1'b1);
    cyc(3);
    expect_poll("t5_poll");
    busy_hold = 1'b0;
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h48; data_i = 32'h3;
    exp_q.delete();
    #1;
    check("t5_we_suppressed", {31'h0, uart_we_o}, 32'h0);
    @(negedge clk);
    req_i = 1'b0; we_i = 1'b0; addr_i = 32'h0; data_i = 32'h0;
    #1;
    check("t5_fsm_idle", {31'h0, uart_req_o}, 32'h0);
    bus_rd(8'h44, rd); check("t5_status", rd, 32'h0000_0002);

    // 6: async reset mid-WRITE
    busy_hold = 1'b1;
    push(8'hC3, 1'b1);
    cyc(3);
    expect_poll("t6_poll");
    busy_hold = 1'b0;
    @(negedge clk);
    #1;
    check("t6_in_write", {31'h0, uart_we_o}, 32'h1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("t6_we_drop", {31'h0, uart_we_o}, 32'h0);
    check("t6_req_drop", {31'h0, uart_req_o}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus_rd(8'h44, rd); check("t6_status", rd, 32'h0000_0002);
    bus_rd(8'h48, rd); check("t6_ctrl", rd, 32'h0);

    cyc(5);
    check("final_tx_count", 32'(n_tx), 32'd21);
    check("final_queue_empty", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
